rfdp_fifo_ctrl: RTL

Single-clock FIFO controller that drives one external 1-write/1-read dual-port SRAM macro (rfdp`<depth>`x`<width>` family, e.g. rfdp128x16) and presents valid/ready streaming ports on both sides. It sits directly upstream of the SRAM, buffering camera-pixel or CNN-activation streams between producer and consumer stages. It hides the macro's one-cycle read latency with a two-entry prefetch output buffer, so the read side sustains one word per cycle.

---
 rtl/rfdp_fifo_pkg.sv | 18 +
 rtl/rfdp_fifo_obuf.sv | 60 ++++++
 rtl/rfdp_fifo_ctrl.sv | 119 +++++++++++
 3 files changed

// File: rtl/rfdp_fifo_pkg.sv
// rfdp_fifo_pkg: shared types and constants for the rfdp FIFO controller.
//   ptr_w()     : width of the wrap-bit-extended SRAM pointers for a given depth
//   obuf_cnt_t  : occupancy count of the 2-entry output buffer
//   OBUF_DEPTH  : output buffer depth (2 hides the SRAM's one-cycle read latency)
package rfdp_fifo_pkg;

    localparam int OBUF_DEPTH = 2;

    typedef logic [1:0] obuf_cnt_t;

    localparam obuf_cnt_t OBUF_FULL = obuf_cnt_t'(OBUF_DEPTH);

    // Address bits plus one wrap bit.
    function automatic int ptr_w(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/rfdp_fifo_obuf.sv
// rfdp_fifo_obuf: 2-entry output buffer sitting behind the SRAM read port.
//   clk, rst_n : clock, asynchronous active-low reset
//   flush_i    : synchronous clear of the occupancy (data regs left as-is)
//   push_i     : write data_i into the next free entry
//   pop_i      : drop the head entry (ignored when empty)
//   cnt_o      : entries held (0..2)
//   head_o     : head entry, straight from a register
// The caller guarantees a push never arrives when the buffer is full and no
// pop frees an entry in the same cycle.
module rfdp_fifo_obuf
    import rfdp_fifo_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush_i,
    input  logic             push_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic             pop_i,
    output obuf_cnt_t        cnt_o,
    output logic [WIDTH-1:0] head_o
);

    logic [WIDTH-1:0] e0_q, e0_d, e1_q, e1_d;
    obuf_cnt_t        cnt_q, cnt_d;

    always_comb begin
        e0_d  = e0_q;
        e1_d  = e1_q;
        cnt_d = cnt_q;
        // Pop first so a same-cycle push lands in the slot the pop freed.
        if (pop_i && cnt_q != 2'd0) begin
            e0_d  = e1_q;
            cnt_d = cnt_q - 2'd1;
        end
        if (push_i) begin
            if (cnt_d == 2'd0) e0_d = data_i;
            else               e1_d = data_i;
            cnt_d = cnt_d + 2'd1;
        end
        if (flush_i) cnt_d = '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            e0_q  <= '0;
            e1_q  <= '0;
            cnt_q <= '0;
        end else begin
            e0_q  <= e0_d;
            e1_q  <= e1_d;
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o  = cnt_q;
    assign head_o = e0_q;

endmodule

// File: rtl/rfdp_fifo_ctrl.sv
// rfdp_fifo_ctrl: single-clock valid/ready FIFO controller for an external
// 1W/1R dual-port SRAM macro with one-cycle read latency. A 2-entry output
// buffer is prefetched so the read side streams one word per cycle.
//   clk, rst_n                  : clock (also the macro clocks), async active-low reset
//   flush                       : synchronous clear of all contents
//   s_valid/s_ready/s_data      : write-side stream
//   m_valid/m_ready/m_data      : read-side stream (m_data registered)
//   level                       : words held in SRAM + in-flight read + output buffer
//   sram_aa/sram_cena/sram_qa   : macro read port (CENA active-low, QA next cycle)
//   sram_ab/sram_db/sram_cenb   : macro write port (CENB active-low)
// Optional feature: define RFDP_FIFO_BYPASS_EN to steer a word accepted into
// an otherwise empty pipeline straight into the output buffer, skipping SRAM.
module rfdp_fifo_ctrl
    import rfdp_fifo_pkg::*;
#(
    parameter  int DEPTH = 128,
    parameter  int WIDTH = 16,
    localparam int AW    = $clog2(DEPTH),
    localparam int LW    = $clog2(DEPTH + 3)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             s_valid,
    output logic             s_ready,
    input  logic [WIDTH-1:0] s_data,
    output logic             m_valid,
    input  logic             m_ready,
    output logic [WIDTH-1:0] m_data,
    output logic [LW-1:0]    level,
    output logic [AW-1:0]    sram_aa,
    output logic             sram_cena,
    input  logic [WIDTH-1:0] sram_qa,
    output logic [AW-1:0]    sram_ab,
    output logic [WIDTH-1:0] sram_db,
    output logic             sram_cenb
);

    localparam int PW = ptr_w(DEPTH);

    logic [PW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic             inflight_q, inflight_d;
    obuf_cnt_t        obuf_cnt;
    logic             sram_empty, sram_full;
    logic             wr_hs, wr_en, rd_en, byp, pop, obuf_push;
    logic [2:0]       pending;
    logic [WIDTH-1:0] obuf_din;

    assign sram_empty = (wr_ptr_q == rd_ptr_q);
    assign sram_full  = (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]) &&
                        (wr_ptr_q[AW] != rd_ptr_q[AW]);

    assign s_ready = !sram_full && !flush;
    assign wr_hs   = s_valid && s_ready;
    assign pop     = m_valid && m_ready;

`ifdef RFDP_FIFO_BYPASS_EN
    // Only when nothing older sits in SRAM or in flight, so order holds.
    assign byp = wr_hs && sram_empty && !inflight_q && (obuf_cnt < OBUF_FULL);
`else
    assign byp = 1'b0;
`endif

    assign wr_en = wr_hs && !byp;

    // Output-buffer slots already spoken for, net of this cycle's pop. Counting
    // the pop lets a read issue every cycle while streaming; without it the
    // pipeline would bubble every other word. Keeps obuf_cnt + inflight <= 2.
    assign pending = {1'b0, obuf_cnt} + {2'b0, inflight_q} - {2'b0, pop};
    assign rd_en   = !flush && !sram_empty && (pending < 3'd2);

    // Returning read data is dropped on flush; bypass never coincides with a
    // returning read because it requires inflight_q == 0.
    assign obuf_push = (inflight_q && !flush) || byp;
    assign obuf_din  = inflight_q ? sram_qa : s_data;

    always_comb begin
        wr_ptr_d   = wr_ptr_q + PW'(wr_en);
        rd_ptr_d   = rd_ptr_q + PW'(rd_en);
        inflight_d = rd_en;
        if (flush) begin
            wr_ptr_d   = '0;
            rd_ptr_d   = '0;
            inflight_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            inflight_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            inflight_q <= inflight_d;
        end
    end

    rfdp_fifo_obuf #(.WIDTH(WIDTH)) u_obuf (
        .clk     (clk),
        .rst_n   (rst_n),
        .flush_i (flush),
        .push_i  (obuf_push),
        .data_i  (obuf_din),
        .pop_i   (pop),
        .cnt_o   (obuf_cnt),
        .head_o  (m_data)
    );

    assign m_valid   = (obuf_cnt != 2'd0);
    assign sram_aa   = rd_ptr_q[AW-1:0];
    assign sram_cena = !rd_en;
    assign sram_ab   = wr_ptr_q[AW-1:0];
    assign sram_cenb = !wr_en;
    assign sram_db   = wr_en ? s_data : '0;
    assign level     = LW'(wr_ptr_q - rd_ptr_q) + LW'(inflight_q) + LW'(obuf_cnt);

endmodule
